// File: rtl/uint_sub_pkg.sv
// Shared types and helpers for the bit-serial unsigned subtractor.
package uint_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to index WIDTH bits, never narrower than 1.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout on underflow.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/uint_sub_serial.sv
// Bit-serial unsigned subtractor O = I0 - I1 mod 2^WIDTH with borrow-out and
// valid/ready handshakes. Define UINT_SUB_SAT_EN for a saturating (clamp-to-0) result.
module uint_sub_serial
  import uint_sub_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] O,
  output logic             borrow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_q, res_next, o_q;
  logic [CW-1:0]    cnt_q;
  logic             bw_q, borrow_q;
  logic             d_bit, bout;
  logic             accept, last_bit;

  full_sub_bit u_bit (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bw_q),
    .d    (d_bit),
    .bout (bout)
  );

  // LSB-first: each new difference bit enters at the MSB and the result slides right.
  assign res_next = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      o_q      <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= I0;
      b_sr  <= I1;
      res_q <= '0;
      cnt_q <= '0;
      bw_q  <= 1'b0;
    end else if (state_q == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res_q <= res_next;
      bw_q  <= bout;
      cnt_q <= cnt_q + 1'b1;
      if (last_bit) begin
`ifdef UINT_SUB_SAT_EN
        o_q <= bout ? '0 : res_next;
`else
        o_q <= res_next;
`endif
        borrow_q <= bout;
      end
    end
  end

  assign O      = o_q;
  assign borrow = borrow_q;

endmodule

// File: doc/uint_sub_serial.md
Name: uint_sub_serial

Overview:
Bit-serial unsigned subtractor computing O = I0 - I1 mod 2^WIDTH, plus a borrow-out flag. It is the sequential, area-lean counterpart of the combinational UInt add primitive. It is used where a full-width subtractor is too costly and a multi-cycle latency is acceptable. Operands and results move over independent valid/ready handshakes, so the block drops into streaming datapaths.

Parameters:
WIDTH, 3, operand/result width in bits; legal range 1..64.

Ports:
- CLK  input  1  rising-edge clock
- ASYNCRESETN  input  1  asynchronous reset, active-low
- I0  input  WIDTH  minuend
- I1  input  WIDTH  subtrahend
- in_valid  input  1  I0/I1 valid
- in_ready  output  1  block can accept operands
- O  output  WIDTH  difference
- borrow  output  1  set when I0 < I1 (unsigned)
- out_valid  output  1  O/borrow valid
- out_ready  input  1  consumer accepts result

Behaviour:
- Reset (ASYNCRESETN low, takes effect immediately):
  - state=IDLE, in_ready=1, out_valid=0, O=0, borrow=0, bit counter=0, internal borrow=0.
  - Reset mid-operation abandons the operation with no result. After release the block is in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch I0 into shift register A and I1 into shift register B; clear result register and carry-borrow; cnt=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, bit cnt is computed:
    - d = A[0]^B[0]^b
    - b' = (~A[0]&B[0]) | (~(A[0]^B[0])&b)
  - d shifts into the result MSB and A/B shift right. cnt increments.
  - When cnt==WIDTH-1, go to DONE with O=result and borrow=b'.
- DONE:
  - out_valid=1; O/borrow held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, with out_valid low next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Latency:
  - Accepting edge at cycle T; out_valid is high from cycle T+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles.
- Inputs are ignored outside IDLE; in_valid may toggle freely there.
- out_ready is ignored outside DONE.
- WIDTH=1: RUN lasts one cycle.
- Wrap-around: the result is modulo 2^WIDTH (e.g. 0-1 gives all ones, borrow=1).
- The counter is $clog2(WIDTH) bits wide, minimum 1.

Optional Feature:
- Macro: UINT_SUB_SAT_EN.
- Defined: on entry to DONE, if the final borrow=1, O is forced to 0 (saturating subtract). The borrow output is still 1.
- Undefined: O is the modular difference. Area contains no clamp logic.

Decomposition:
- Package uint_sub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - function cnt_w(WIDTH) returning max(1,$clog2(WIDTH))
- One sub-module, full_sub_bit: combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once inside the RUN datapath.

Test Plan:
All cases use WIDTH=3 unless noted.
- I0=5, I1=3, accept at T -> out_valid at T+3, O=2, borrow=0; in_ready low T+1..DONE exit.
- I0=3, I1=5 -> O=6, borrow=1. With UINT_SUB_SAT_EN: O=0, borrow=1.
- I0=7, I1=7 -> O=0, borrow=0. Also I0=0, I1=1 -> O=7, borrow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> O/borrow/out_valid stable. Toggling in_valid with new operands has no effect. Raising out_ready -> IDLE next cycle.
- Reset mid-RUN (assert ASYNCRESETN low after 1 bit) -> outputs immediately reach reset values. A new op 4-1 afterwards gives O=3, borrow=0.
- Back-to-back stream of 50 random pairs with random out_ready, and WIDTH=1 and WIDTH=16 variants -> every result matches the (I0-I1) mod 2^WIDTH reference model in order, with no drops or duplicates.
